// File: rtl/matrix_alu_pkg.sv
// Shared definitions for the matrix operation sequencer and the matrix ALU it drives:
// op codes, ALU select bases and the sequencer state encoding.
package matrix_alu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_E = 3'd1,
    ST_LOAD_F = 3'd2,
    ST_LOAD_C = 3'd3,
    ST_EXEC   = 3'd4,
    ST_SETTLE = 3'd5,
    ST_DRAIN  = 3'd6
  } state_e;

  localparam logic [2:0] OP_TRANSPOSE = 3'd0;
  localparam logic [2:0] OP_ADD       = 3'd1;
  localparam logic [2:0] OP_SUB       = 3'd2;
  localparam logic [2:0] OP_MUL       = 3'd3;
  localparam logic [2:0] OP_SCALE     = 3'd4;
  localparam logic [2:0] OP_DET       = 3'd5;

  localparam logic [5:0] SEL_E    = 6'd0;
  localparam logic [5:0] SEL_F    = 6'd9;
  localparam logic [5:0] SEL_G    = 6'd18;
  localparam logic [5:0] SEL_DET  = 6'd27;
  localparam logic [5:0] SEL_EXEC = 6'd28;
  localparam logic [5:0] SEL_C    = 6'd40;

  localparam logic [3:0] ELE_LAST = 4'd8;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= OP_DET;
  endfunction

endpackage

// File: rtl/matrix_op_sequencer.sv
// Sequences one 3x3 matrix command: streams operands into the matrix ALU, fires the
// operation, then streams the result elements back out.
module matrix_op_sequencer
  import matrix_alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic [5:0]  alu_sel,
  output logic [31:0] alu_ele_in,
  input  logic [31:0] alu_ele_out,
  output logic        busy,
  output logic        err_op,
  output logic [2:0]  dbg_state
);

  // Handshakes: a word/command transfers on a rising edge where valid and ready are both
  // high; valid never waits on ready, and ready depends only on state, never on valid.

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic        err_q, err_d;
  logic        last_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= OP_TRANSPOSE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    err_d      = 1'b0;
    cmd_ready  = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    alu_sel    = SEL_DET;
    alu_ele_in = 32'd0;
    last_word  = (op_q == OP_DET) || (cnt_q == ELE_LAST);

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        cnt_d     = 4'd0;
        if (cmd_valid) begin
          if (op_is_legal(cmd_op)) begin
            op_d    = cmd_op;
            state_d = ST_LOAD_E;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD_E: begin
        in_ready = 1'b1;
        if (in_valid) begin
          alu_sel    = SEL_E + {2'b00, cnt_q};
          alu_ele_in = in_data;
          if (cnt_q == ELE_LAST) begin
            cnt_d = 4'd0;
            unique case (op_q)
              OP_ADD, OP_SUB, OP_MUL: state_d = ST_LOAD_F;
              OP_SCALE:               state_d = ST_LOAD_C;
              default:                state_d = ST_EXEC;
            endcase
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_LOAD_F: begin
        in_ready = 1'b1;
        if (in_valid) begin
          alu_sel    = SEL_F + {2'b00, cnt_q};
          alu_ele_in = in_data;
          if (cnt_q == ELE_LAST) begin
            cnt_d   = 4'd0;
            state_d = ST_EXEC;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_LOAD_C: begin
        in_ready = 1'b1;
        if (in_valid) begin
          alu_sel    = SEL_C;
          alu_ele_in = in_data;
          cnt_d      = 4'd0;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_sel = SEL_EXEC + {3'b000, op_q};
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        out_last  = last_word;
        // The determinant is a single scalar read through the read-only select.
        alu_sel   = (op_q == OP_DET) ? SEL_DET : (SEL_G + {2'b00, cnt_q});
        if (out_ready) begin
          if (last_word) begin
            cnt_d   = 4'd0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign out_data  = alu_ele_out;
  assign busy      = (state_q != ST_IDLE);
  assign err_op    = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Bench for matrix_op_sequencer: a stand-in matrix ALU, a command-level reference model
// with an expected-result queue, per-cycle comparison and directed command vectors.
module tb_matrix_op_sequencer;

  typedef logic [31:0] mat_t [9];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;
  logic [5:0]  alu_sel;
  logic [31:0] alu_ele_in;
  logic [31:0] alu_ele_out;
  logic        busy;
  logic        err_op;
  logic [2:0]  dbg_state;

  matrix_op_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .alu_sel(alu_sel), .alu_ele_in(alu_ele_in), .alu_ele_out(alu_ele_out),
    .busy(busy), .err_op(err_op), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  // Matrix semantics: row-major 3x3, 32-bit wrapping arithmetic.
  function automatic void compute(input int op, input mat_t e, input mat_t f,
                                  input logic [31:0] c, output mat_t r);
    for (int i = 0; i < 9; i++) r[i] = 32'd0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        case (op)
          0: r[i*3+j] = e[j*3+i];
          1: r[i*3+j] = e[i*3+j] + f[i*3+j];
          2: r[i*3+j] = e[i*3+j] - f[i*3+j];
          3: r[i*3+j] = e[i*3]*f[j] + e[i*3+1]*f[3+j] + e[i*3+2]*f[6+j];
          4: r[i*3+j] = c * e[i*3+j];
          default: ;
        endcase
    if (op == 5)
      r[0] = e[0]*(e[4]*e[8] - e[5]*e[7]) - e[1]*(e[3]*e[8] - e[5]*e[6])
           + e[2]*(e[3]*e[7] - e[4]*e[6]);
  endfunction

  // ---------------- stand-in matrix ALU ----------------
  mat_t        alu_e, alu_f, alu_g, alu_tmp;
  logic [31:0] alu_c = 32'd0, alu_det = 32'd0;

  always @(negedge clk) begin
    int s;
    s = int'(alu_sel);
    if (s < 9) alu_e[s] = alu_ele_in;
    else if (s < 18) alu_f[s-9] = alu_ele_in;
    else if (s == 40) alu_c = alu_ele_in;
    else if (s >= 28 && s <= 33) begin
      compute(s - 28, alu_e, alu_f, alu_c, alu_tmp);
      if (s == 33) alu_det = alu_tmp[0];
      else alu_g = alu_tmp;
    end
  end

  always_comb begin
    alu_ele_out = 32'hDEAD_BEEF;
    if (alu_sel >= 6'd18 && alu_sel <= 6'd26) alu_ele_out = alu_g[int'(alu_sel) - 18];
    else if (alu_sel == 6'd27) alu_ele_out = alu_det;
  end

  // ---------------- command-level reference model ----------------
  logic        m_busy = 1'b0, m_err = 1'b0;
  int          m_op = 0, m_in_left = 0, m_idx = 0, m_post = 0, m_out_idx = 0;
  mat_t        m_e, m_f, m_r;
  logic [31:0] m_c = 32'd0;
  logic [31:0] exp_q[$];

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0; m_err = 1'b0; m_in_left = 0; m_idx = 0; m_post = 0; m_out_idx = 0;
      exp_q.delete();
    end else if (!m_busy) begin
      m_err = cmd_valid && (cmd_op > 3'd5);
      if (cmd_valid && cmd_op <= 3'd5) begin
        m_busy = 1'b1; m_op = int'(cmd_op); m_idx = 0; m_post = 0; m_out_idx = 0;
        m_in_left = 9 + ((m_op >= 1 && m_op <= 3) ? 9 : (m_op == 4) ? 1 : 0);
      end
    end else begin
      m_err = 1'b0;
      if (m_in_left > 0) begin
        if (in_valid) begin
          if (m_idx < 9) m_e[m_idx] = in_data;
          else if (m_op == 4) m_c = in_data;
          else m_f[m_idx-9] = in_data;
          m_idx++;
          m_in_left--;
          if (m_in_left == 0) begin
            compute(m_op, m_e, m_f, m_c, m_r);
            if (m_op == 5) exp_q.push_back(m_r[0]);
            else for (int i = 0; i < 9; i++) exp_q.push_back(m_r[i]);
          end
        end
      end else if (m_post < 2) begin
        m_post++;
      end else if (out_ready) begin
        void'(exp_q.pop_front());
        m_out_idx++;
        if (exp_q.size() == 0) m_busy = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [31:0] got_q[$];
  logic        got_last_q[$];
  logic [5:0]  exec_sel_seen = 6'd0;
  int          sel40_cnt = 0;

  always @(negedge clk) begin
    logic load, exec, drain;
    if (chk_en) begin
      load  = m_busy && m_in_left > 0;
      exec  = m_busy && m_in_left == 0 && m_post == 0;
      drain = m_busy && m_in_left == 0 && m_post == 2;
      chk("cmd_ready", cmd_ready, !m_busy);
      chk("in_ready", in_ready, load);
      chk("busy", busy, m_busy);
      chk("out_valid", out_valid, drain);
      chk("err_op", err_op, m_err);
      if (alu_sel == 6'd40) sel40_cnt++;
      if (load && in_valid) begin
        chk("load_sel", alu_sel, (m_idx >= 9 && m_op == 4) ? 32'd40 : 32'(m_idx));
        chk("load_ele", alu_ele_in, in_data);
        chk("load_last", out_last, 0);
      end else if (exec) begin
        exec_sel_seen = alu_sel;
        chk("exec_sel", alu_sel, 32'(28 + m_op));
        chk("exec_ele", alu_ele_in, 0);
      end else if (drain) begin
        chk("drain_sel", alu_sel, (m_op == 5) ? 32'd27 : 32'(18 + m_out_idx));
        chk("drain_data", out_data, exp_q[0]);
        chk("drain_last", out_last, exp_q.size() == 1);
        chk("drain_ele", alu_ele_in, 0);
        if (out_ready) begin
          got_q.push_back(out_data);
          got_last_q.push_back(out_last);
        end
      end else begin
        chk("idle_sel", alu_sel, 27);
        chk("idle_ele", alu_ele_in, 0);
        chk("idle_last", out_last, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [2:0] op);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      if (++n > 100) begin timeout("cmd_handshake"); break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] data, input int gap);
    int n = 0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data = data;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++n > 100) begin timeout("in_handshake"); break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      if (++n > 200) begin timeout("wait_idle"); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_cmd(input logic [2:0] op, input mat_t e, input mat_t f,
                         input logic [31:0] c, input int gap_at,
                         input int stall_at, input logic [31:0] hold_data);
    int n = 0;
    got_q.delete();
    got_last_q.delete();
    sel40_cnt = 0;
    send_cmd(op);
    for (int i = 0; i < 9; i++) send_word(e[i], (i == gap_at) ? 2 : 0);
    if (op >= 3'd1 && op <= 3'd3) for (int i = 0; i < 9; i++) send_word(f[i], 0);
    if (op == 3'd4) send_word(c, 0);
    if (stall_at >= 0) begin
      forever begin
        if (got_q.size() == stall_at) break;
        if (++n > 100) begin timeout("stall_wait"); break; end
        @(posedge clk); #1;
      end
      out_ready = 1'b0;
      repeat (5) begin
        @(negedge clk);
        chk("hold_sel", alu_sel, 32'(18 + stall_at));
        chk("hold_data", out_data, hold_data);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    wait_idle();
  endtask

  task automatic chk_got(input string name, input mat_t lit, input int n);
    chk({name, "_count"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      chk({name, "_word"}, got_q[i], lit[i]);
      chk({name, "_last"}, got_last_q[i], i == n - 1);
    end
  endtask

  // ---------------- stimulus ----------------
  mat_t e_seq  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  mat_t f_ten  = '{10, 10, 10, 10, 10, 10, 10, 10, 10};
  mat_t ones   = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
  mat_t ident  = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
  mat_t diag   = '{2, 0, 0, 0, 3, 0, 0, 0, 4};
  mat_t lit_add   = '{11, 12, 13, 14, 15, 16, 17, 18, 19};
  mat_t lit_det   = '{24, 0, 0, 0, 0, 0, 0, 0, 0};
  mat_t lit_scale = '{3, 0, 0, 0, 3, 0, 0, 0, 3};
  mat_t lit_tr    = '{1, 4, 7, 2, 5, 8, 3, 6, 9};
  mat_t lit_sub   = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
  mat_t lit_mul   = '{2, 6, 12, 8, 15, 24, 14, 24, 36};

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_sel", alu_sel, 27);
    chk("rst_alu_ele_in", alu_ele_in, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_cmd(3'd1, e_seq, f_ten, 0, -1, -1, 0);
    chk_got("add", lit_add, 9);
    chk("add_exec_sel", exec_sel_seen, 29);

    run_cmd(3'd5, diag, f_ten, 0, 4, -1, 0);
    chk_got("det", lit_det, 1);
    chk("det_exec_sel", exec_sel_seen, 33);

    run_cmd(3'd4, ident, f_ten, 3, -1, -1, 0);
    chk_got("scale", lit_scale, 9);
    chk("scale_sel40_count", 32'(sel40_cnt), 1);

    run_cmd(3'd0, e_seq, f_ten, 0, -1, 2, 7);
    chk_got("transpose", lit_tr, 9);

    run_cmd(3'd2, e_seq, ones, 0, 0, -1, 0);
    chk_got("sub", lit_sub, 9);

    run_cmd(3'd3, e_seq, diag, 0, 8, -1, 0);
    chk_got("mul", lit_mul, 9);

    send_cmd(3'd6);
    @(negedge clk);
    chk("err_pulse", err_op, 1);
    chk("err_busy", busy, 0);
    @(negedge clk);
    chk("err_clear", err_op, 0);
    @(posedge clk); #1;

    // Abort an add while its fifth F word is being offered.
    send_cmd(3'd1);
    for (int i = 0; i < 9; i++) send_word(e_seq[i], 0);
    for (int i = 0; i < 4; i++) send_word(f_ten[i], 0);
    in_valid = 1'b1;
    in_data = 32'd77;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk); #1;

    run_cmd(3'd1, e_seq, f_ten, 0, -1, -1, 0);
    chk_got("add_after_abort", lit_add, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL global_timeout reached at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_op_sequencer.md
MATRIX_OP_SEQUENCER -- requirements
Module: matrix_op_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports cmd_valid (input, 1), cmd_ready (output, 1) and cmd_op (input, 3) forming the command handshake. Op codes: 0 transpose, 1 add, 2 sub, 3 mul, 4 scale, 5 det.
REQ-004 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, 32) forming the operand word stream.
REQ-005 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, 32) and out_last (output, 1) forming the result word stream.
REQ-006 SHALL have ports alu_sel (output, 6) and alu_ele_in (output, 32): select and element driven to the downstream matrix ALU.
REQ-007 SHALL have port alu_ele_out, input, 32 bits: element returned by the matrix ALU.
REQ-008 SHALL have port busy (output, 1): high in every state except IDLE.
REQ-009 SHALL have port err_op (output, 1): one-cycle pulse on an illegal op code.

Function
REQ-010 SHALL implement states IDLE, LOAD_E, LOAD_F, LOAD_C, EXEC, SETTLE and DRAIN.
REQ-011 IDLE: SHALL assert cmd_ready; a handshake with op 0..5 SHALL latch the op and move to LOAD_E.
REQ-012 In IDLE, op 6 or 7 SHALL be acknowledged, pulse err_op the next cycle and stay in IDLE.
REQ-013 LOAD_E SHALL accept 9 words in row-major order (E00..E22).
- Word k is accepted when in_valid and in_ready are both high.
- On that cycle alu_sel = k and alu_ele_in = in_data.
REQ-014 After the 9th word, LOAD_E SHALL go to LOAD_F for ops 1/2/3, LOAD_C for op 4, and EXEC for ops 0/5.
REQ-015 LOAD_F SHALL accept 9 words with alu_sel = 9+k, then go to EXEC.
REQ-016 LOAD_C SHALL accept 1 word with alu_sel = 40, then go to EXEC.
REQ-017 in_ready SHALL be high only in LOAD_E, LOAD_F and LOAD_C; gaps in in_valid SHALL stall without side effect.
REQ-018 When no word transfers, alu_sel SHALL be 27 (read-only select) and alu_ele_in SHALL be 0.
REQ-019 EXEC SHALL last exactly one cycle with alu_sel = 28 + op (28..33).
REQ-020 SETTLE SHALL last one cycle with alu_sel = 27, then go to DRAIN.
REQ-021 DRAIN SHALL emit the result words.
- Ops 0..4: 9 words with alu_sel = 18+k.
- Op 5: 1 word with alu_sel = 27.
- out_data SHALL equal alu_ele_out combinationally.
REQ-022 out_valid SHALL be high only in DRAIN. alu_sel and out_data SHALL be held stable while out_valid is high and out_ready is low.
REQ-023 out_last SHALL be high with the final word (9th word, or the only det word).
REQ-024 The final output handshake SHALL return the block to IDLE. cmd_ready SHALL be high on the next cycle.
REQ-025 Minimum latency from the last operand accept to the first out_valid SHALL be 2 cycles (EXEC, SETTLE).
REQ-026 Element counter SHALL be 4 bits, SHALL clear on every state change, and SHALL never exceed 8.
REQ-027 in_valid SHALL be ignored outside load states. cmd_valid SHALL be ignored outside IDLE.

Reset
REQ-028 Reset SHALL force IDLE, counter 0, op 0, alu_sel 27, alu_ele_in 0, and cmd_ready 1.
REQ-029 Reset SHALL force in_ready, out_valid, out_last, busy and err_op to 0.
REQ-030 Reset asserted mid-load or mid-drain SHALL abort the command. No further words SHALL be accepted or emitted for it.

Structure
REQ-031 Op codes, sel base constants (E=0, F=9, G=18, DET=27, C=40, EXEC=28) and the state enum SHALL live in shared package matrix_alu_pkg.
REQ-032 SHALL be a single module with no sub-modules; the top level instantiates it beside the matrix ALU.

Verification
REQ-033 Add, E=1..9, F=all 10, out_ready=1 -> alu_sel 0..17 then 29, then outputs 11..19 with out_last on 19.
REQ-034 Det, E=[2,0,0; 0,3,0; 0,0,4] -> alu_sel 33 in EXEC, then a single word 24 with out_last.
REQ-035 Scale, c=3, E=identity -> alu_sel 40 once, then outputs 3,0,0,0,3,0,0,0,3.
REQ-036 Transpose with out_ready low 5 cycles on word 2 -> out_data and alu_sel held at 20 for those cycles, no word lost.
REQ-037 cmd_op=6 -> err_op pulses one cycle, busy stays 0; reset during LOAD_F word 4 -> IDLE next cycle, in_ready 0.
